vec_wb_addr_seq: RTL and testbench
==================================

Name: vec_wb_addr_seq

Overview:
- Write-side counterpart of the read address generator (addr_gen_unit).
- On start, latches a destination vector register base and an LMUL code.
- Accepts 2^vlmul result beats from the execution pipeline and emits registered vector-register-file write strobes (address, data, enable) for base, base+1, ...
- Reports idle, done and a protocol-error flag to the issue controller.

Parameters:
- ADDR_WIDTH, 5, vector register index width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 64, width of one result beat and one register write.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only while idle.
- vlmul  in  3  LMUL code; sampled with en.
- addr_in  in  ADDR_WIDTH  destination base register; sampled with en.
- res_valid  in  1  result beat valid.
- res_data  in  DATA_WIDTH  result beat payload.
- res_ready  out  1  beat accepted when res_valid && res_ready at a rising edge.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  ADDR_WIDTH  register-file write address.
- wr_data  out  DATA_WIDTH  register-file write data.
- idle  out  1  high when no group is in progress.
- done  out  1  one-cycle pulse with the final write of a group.
- err  out  1  sticky; set by a beat arriving while idle.

Behaviour:
- Reset (rst low, asynchronous) forces these values immediately:
  - state IDLE, idle=1, res_ready=0
  - wr_en=0, wr_addr=0, wr_data=0
  - done=0, err=0, beat counter=0
  - Reset mid-group abandons the group; no further writes.
- Beat count N comes from vlmul:
  - 000 → 1, 001 → 2, 010 → 4, 011 → 8.
  - 1xx (fractional LMUL) → 1.
  - The latched code decides N; later vlmul changes are ignored.
- State IDLE:
  - idle=1, res_ready=0.
  - At a rising edge with en=1: latch base=addr_in and N, clear counter, go to BUSY.
  - idle falls in the following cycle.
- State BUSY:
  - idle=0, res_ready=1.
  - en is ignored, including deassertion; the group always runs to completion.
- Each accepted beat k (0..N-1):
  - Next cycle: wr_en=1, wr_addr=(base+k) mod 2^ADDR_WIDTH, wr_data=res_data of that beat.
  - Latency from acceptance to write is exactly 1 cycle.
  - A cycle with no accepted beat gives wr_en=0 in the next cycle; wr_addr and wr_data hold their last values.
- Last beat (k=N-1) accepted:
  - State returns to IDLE at that edge.
  - The next cycle shows wr_en=1, done=1 and idle=1 together.
- Back-to-back groups:
  - en held high during the final-write cycle starts a new group at that edge.
  - The minimum gap between the last write of one group and the first acceptance of the next is one cycle.
- Address wrap: base=30, N=4 writes 30, 31, 0, 1. Addresses are not checked for alignment.
- res_valid=1 in IDLE: the beat is dropped (no write), err is set and stays 1 until reset. This holds in the same cycle as en too: that beat is dropped and flagged.
- Counter width is 3 bits; it never exceeds N-1.

Decomposition:
- Shared package (vec_pkg):
  - LMUL encoding constants (LMUL_1/2/4/8, LMUL_FRAC_MSB).
  - A function lmul_beats(vlmul) returning N; also used by the read address generator, so the two ends agree.
  - FSM state typedef {IDLE, BUSY}.
- No sub-module; a single FSM plus counter plus output register stage is natural.

Test Plan:
- Reset release, then en=1, addr_in=1, vlmul=010, res_valid held high → writes to 1, 2, 3, 4 on consecutive cycles; done and idle=1 together on the write to 4.
- While BUSY from a group started with addr_in=1, apply addr_in=3, vlmul=001 → ignored, addresses still 1..4. After idle, the next en takes addr_in=3, vlmul=001 → writes to 3, 4.
- addr_in=3, vlmul=011, en dropped one cycle after start → full 8 writes (3..10) complete; done pulses once.
- addr_in=30, vlmul=010, res_valid asserted on alternate cycles → writes to 30, 31, 0, 1, each one cycle after its beat; wr_en low in gap cycles.
- vlmul=101, addr_in=7 → single write to 7 with done. A res_valid pulse while idle → no write, err=1 and stays high.
- rst pulsed low mid-group (after 2 of 8 beats) → all outputs go to reset values asynchronously, no further writes; a new en after release starts cleanly from the new addr_in.

Source files
------------

// File: rtl/vec_wb_addr_seq_pkg.sv
// Shared vector-unit definitions: LMUL encodings, the beat-count helper that the
// read and write address sequencers both use, and the write sequencer FSM states.
package vec_pkg;

  localparam logic [2:0] LMUL_1        = 3'b000;
  localparam logic [2:0] LMUL_2        = 3'b001;
  localparam logic [2:0] LMUL_4        = 3'b010;
  localparam logic [2:0] LMUL_8        = 3'b011;
  localparam int         LMUL_FRAC_MSB = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } seq_state_t;

  // Registers per group; fractional LMUL still occupies one whole register.
  function automatic logic [3:0] lmul_beats(input logic [2:0] vlmul);
    logic [3:0] n;
    n = 4'd1;
    if (vlmul[LMUL_FRAC_MSB]) begin
      n = 4'd1;
    end else begin
      case (vlmul)
        LMUL_1:  n = 4'd1;
        LMUL_2:  n = 4'd2;
        LMUL_4:  n = 4'd4;
        LMUL_8:  n = 4'd8;
        default: n = 4'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/vec_wb_addr_seq.sv
// Vector write-back address sequencer: turns a group of result beats into
// registered register-file writes at base, base+1, ... with done/idle/err status.
module vec_wb_addr_seq
  import vec_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            vlmul,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  idle,
  output logic                  done,
  output logic                  err
);

  seq_state_t            state;
  seq_state_t            next_state;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            last;
  logic [2:0]            cnt;
  logic                  accept;
  logic                  last_beat;
  logic [3:0]            beats_m1;

  assign beats_m1 = lmul_beats(vlmul) - 4'd1;

  // Beat acceptance and next-state decode
  always_comb begin
    accept     = 1'b0;
    last_beat  = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        accept    = res_valid;
        last_beat = res_valid && (cnt == last);
        if (last_beat) begin
          next_state = IDLE;
        end else begin
          next_state = BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Group context: base and last index are latched once, so later vlmul/addr_in changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base <= {ADDR_WIDTH{1'b0}};
      last <= 3'd0;
      cnt  <= 3'd0;
    end else if (state == IDLE) begin
      if (en) begin
        base <= addr_in;
        last <= beats_m1[2:0];
        cnt  <= 3'd0;
      end else begin
        cnt  <= 3'd0;
      end
    end else if (accept) begin
      cnt <= last_beat ? 3'd0 : cnt + 3'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Registered write strobe and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= {ADDR_WIDTH{1'b0}};
      wr_data   <= {DATA_WIDTH{1'b0}};
      done      <= 1'b0;
      err       <= 1'b0;
      idle      <= 1'b1;
      res_ready <= 1'b0;
    end else begin
      wr_en     <= accept;
      done      <= last_beat;
      err       <= err | ((state == IDLE) && res_valid);
      idle      <= (next_state == IDLE);
      res_ready <= (next_state == BUSY);
      if (accept) begin
        wr_addr <= base + ADDR_WIDTH'(cnt);
        wr_data <= res_data;
      end else begin
        wr_addr <= wr_addr;
        wr_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_addr_seq.sv
// Self-checking bench for vec_wb_addr_seq: a group-level reference model plus
// directed scenarios with literal address expectations and a randomized phase.
module tb_vec_wb_addr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  vlmul = 3'd0;
  logic [4:0]  addr_in = 5'd0;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = 64'd0;
  logic        res_ready, wr_en, idle, done, err;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;

  int tests = 0;
  int fails = 0;

  vec_wb_addr_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .en(en), .vlmul(vlmul), .addr_in(addr_in),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .idle(idle), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a group is (base, N, beats taken so far)
  bit          m_busy = 1'b0;
  logic [4:0]  m_base = 5'd0;
  int          m_n = 1;
  int          m_k = 0;
  bit          m_err = 1'b0;
  bit          exp_wr_en = 1'b0;
  bit          exp_done = 1'b0;
  logic [4:0]  exp_wr_addr = 5'd0;
  logic [63:0] exp_wr_data = 64'd0;

  int log_q[$];
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 1'b0; m_base = 5'd0; m_n = 1; m_k = 0; m_err = 1'b0;
        exp_wr_en = 1'b0; exp_done = 1'b0; exp_wr_addr = 5'd0; exp_wr_data = 64'd0;
      end else begin
        bit was_busy;
        was_busy  = m_busy;
        exp_wr_en = was_busy && res_valid;
        exp_done  = 1'b0;
        if (exp_wr_en) begin
          exp_wr_addr = 5'(int'(m_base) + m_k);
          exp_wr_data = res_data;
          m_k++;
          if (m_k == m_n) begin
            exp_done = 1'b1;
            m_busy   = 1'b0;
          end
        end
        if (!was_busy && res_valid) m_err = 1'b1;
        if (!was_busy && en) begin
          m_busy = 1'b1;
          m_base = addr_in;
          m_n    = vlmul[2] ? 1 : (1 << vlmul[1:0]);
          m_k    = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("wr_en", wr_en, exp_wr_en);
      check("wr_addr", wr_addr, exp_wr_addr);
      check("wr_data", wr_data, exp_wr_data);
      check("done", done, exp_done);
      check("idle", idle, !m_busy);
      check("res_ready", res_ready, m_busy);
      check("err", err, m_err);
      if (wr_en) log_q.push_back(int'(wr_addr));
      if (done) n_done++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int first, input int count);
    check({name, " count"}, log_q.size(), count);
    for (int i = 0; i < count && i < log_q.size(); i++)
      check({name, " addr"}, log_q[i], (first + i) % 32);
  endtask

  task automatic start(input logic [4:0] a, input logic [2:0] v);
    log_q.delete();
    n_done = 0;
    en = 1'b1; addr_in = a; vlmul = v; res_valid = 1'b0;
    cyc();
    en = 1'b0;
  endtask

  initial begin
    #22 rst = 1'b1;
    cyc();
    check("reset idle", idle, 1'b1);
    check("reset wr_en", wr_en, 1'b0);

    // Group at 1, LMUL 4; input changes while busy must be ignored
    start(5'd1, 3'b010);
    addr_in = 5'd3; vlmul = 3'b001;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_data = {$urandom, $urandom};
      if (i == 3) begin
        cyc(); res_valid = 1'b0;
        #4 check("t1 done+idle+wr", {done, idle, wr_en, wr_addr}, {3'b111, 5'd4});
      end else cyc();
    end
    cyc();
    check_seq("t1", 1, 4);
    check("t1 done pulses", n_done, 1);

    // Next group takes the new base/LMUL
    start(5'd3, 3'b001);
    res_valid = 1'b1; cyc(); cyc(); res_valid = 1'b0; cyc();
    check_seq("t2", 3, 2);

    // en held one cycle into BUSY, then dropped: group still runs 8 beats
    start(5'd3, 3'b011);
    en = 1'b1; res_valid = 1'b1; res_data = {$urandom, $urandom}; cyc();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin res_data = {$urandom, $urandom}; cyc(); end
    res_valid = 1'b0; cyc(); cyc();
    check_seq("t3", 3, 8);
    check("t3 last addr", log_q.size() == 8 ? log_q[7] : -1, 10);
    check("t3 done pulses", n_done, 1);

    // Wrap with gaps between beats
    start(5'd30, 3'b010);
    for (int i = 0; i < 8; i++) begin
      res_valid = (i % 2 == 0); res_data = {$urandom, $urandom}; cyc();
    end
    res_valid = 1'b0; cyc();
    check_seq("t4", 30, 4);
    check("t4 third addr", log_q.size() >= 3 ? log_q[2] : -1, 0);

    // Fractional LMUL -> single write; then a stray beat while idle
    start(5'd7, 3'b101);
    res_valid = 1'b1; cyc(); res_valid = 1'b0; cyc();
    check_seq("t5", 7, 1);
    check("t5 done pulses", n_done, 1);
    check("t5 err before", err, 1'b0);
    log_q.delete();
    res_valid = 1'b1; cyc(); res_valid = 1'b0; cyc(); cyc();
    check("t5 stray writes", log_q.size(), 0);
    check("t5 err sticky", err, 1'b1);

    // Asynchronous reset mid-group
    start(5'd12, 3'b011);
    res_valid = 1'b1; cyc(); cyc();
    #2 rst = 1'b0;
    #1 check("t6 rst outputs", {wr_en, done, err, idle, res_ready, wr_addr}, {5'b00010, 5'd0});
    cyc(); cyc();
    res_valid = 1'b0;
    cyc();
    log_q.delete();
    rst = 1'b1;
    cyc(); cyc();
    check("t6 no writes after rst", log_q.size(), 0);
    start(5'd20, 3'b000);
    res_valid = 1'b1; cyc(); res_valid = 1'b0; cyc();
    check_seq("t6", 20, 1);

    // Randomized phase, including back-to-back starts and idle beats
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) == 0);
      vlmul     = 3'($urandom_range(0, 7));
      addr_in   = 5'($urandom_range(0, 31));
      res_valid = ($urandom_range(0, 9) < 7);
      res_data  = {$urandom, $urandom};
      cyc();
    end
    en = 1'b0; res_valid = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
